// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches 8-bit instructions from a small program memory, decodes them and
// presents the decoded fields through a valid/ready output register.
// Execution runs from pc 0 after start. It stops when a HALT instruction
// (opcode 4'hE) is accepted by the consumer. A taken branch can redirect
// the fetch address at any time while running.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   prog_we/addr/data   program memory write port (ignored while running)
//   lbl_we/idx/data     16-entry jump-label table write port (ignored while running)
//   start               begin execution at pc 0 (from idle or halted)
//   redirect_valid/pc   taken branch: restart fetching at redirect_pc
//   out_ready           consumer accepts the presented instruction
//   out_valid, out_pc   presented instruction and its pc
//   format, opcode      00 C, 01 I, 10 M, 11 X; instr[7:4]
//   reg1_i, reg2_i,
//   reg_o               register indices
//   imm, imm_flag       instr[3:1], instr[0]
//   jmp_loc             label-table target
//   halted              a HALT instruction was accepted
//   busy                fetch unit is running
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [7:0]      prog_data,
    input  logic            lbl_we,
    input  logic [3:0]      lbl_idx,
    input  logic [PC_W-1:0] lbl_data,
    input  logic            start,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      format,
    output logic [3:0]      opcode,
    output logic [2:0]      reg1_i,
    output logic [2:0]      reg2_i,
    output logic [2:0]      reg_o,
    output logic [2:0]      imm,
    output logic            imm_flag,
    output logic [PC_W-1:0] jmp_loc,
    output logic            halted,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam logic [1:0] FMT_C = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_M = 2'b10;
    localparam logic [1:0] FMT_X = 2'b11;

    state_t          state, state_nxt;
    logic [7:0]      mem    [DEPTH];
    logic [PC_W-1:0] labels [16];
    logic [PC_W-1:0] fetch_pc;

    logic            run, start_acc, halt_acc, redir, load, in_range;
    logic [7:0]      instr;
    logic [1:0]      dec_format;
    logic [2:0]      dec_reg1, dec_reg2, dec_rego;
    logic [PC_W-1:0] dec_jmp;

    // Priority inside RUN: HALT acceptance, then redirect, then load.
    assign run       = (state == S_RUN);
    assign start_acc = start && !run;
    assign halt_acc  = run && out_valid && out_ready && (opcode == 4'hE);
    assign redir     = run && redirect_valid && !halt_acc;
    assign load      = run && !halt_acc && !redir && (!out_valid || out_ready);

    // Addresses beyond the memory read back as HALT so a runaway pc stops.
    assign in_range = ({1'b0, fetch_pc} < (PC_W+1)'(DEPTH));
    assign instr    = in_range ? mem[fetch_pc[AW-1:0]] : 8'hE0;

    always_comb begin
        dec_reg1 = 3'd0;
        dec_reg2 = 3'd0;
        dec_rego = 3'd0;
        dec_jmp  = '0;
        case (instr[7:4])
            4'h2, 4'h4: dec_format = FMT_C;
            4'h9, 4'hD: dec_format = FMT_I;
            4'hE:       dec_format = FMT_X;
            default:    dec_format = FMT_M;
        endcase
        case (dec_format)
            FMT_C: begin
                dec_rego = instr[0] ? 3'b011 : 3'b010;
                dec_jmp  = labels[instr[3:0]];
            end
            FMT_I: begin
                dec_reg1 = instr[3:1];
                dec_reg2 = instr[3:1] + 3'd1;
                dec_rego = instr[3:1];
            end
            FMT_M: begin
                // Opcode 0101 swaps which nibble half feeds source and dest.
                if (instr[7:4] == 4'h5) begin
                    dec_reg1 = {1'b1, instr[1:0]};
                    dec_rego = {1'b0, instr[3:2]};
                end else begin
                    dec_reg1 = {1'b0, instr[3:2]};
                    dec_reg2 = {1'b0, instr[3:2]} + 3'd1;
                    dec_rego = {1'b1, instr[1:0]};
                end
                dec_jmp = labels[{2'b11, instr[1:0]}];
            end
            default: ;
        endcase
    end

    // Program and label storage are not reset so programs survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && !run) mem[prog_addr] <= prog_data;
        if (lbl_we && !run)  labels[lbl_idx] <= lbl_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            out_pc    <= '0;
            format    <= 2'b00;
            opcode    <= 4'h0;
            reg1_i    <= 3'd0;
            reg2_i    <= 3'd0;
            reg_o     <= 3'd0;
            imm       <= 3'd0;
            imm_flag  <= 1'b0;
            jmp_loc   <= '0;
        end else if (start_acc) begin
            fetch_pc  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else if (halt_acc) begin
            out_valid <= 1'b0;
            halted    <= 1'b1;
        end else if (redir) begin
            out_valid <= 1'b0;
            fetch_pc  <= redirect_pc;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= fetch_pc;
            fetch_pc  <= fetch_pc + PC_W'(1);
            format    <= dec_format;
            opcode    <= instr[7:4];
            reg1_i    <= dec_reg1;
            reg2_i    <= dec_reg2;
            reg_o     <= dec_rego;
            imm       <= instr[3:1];
            imm_flag  <= instr[0];
            jmp_loc   <= dec_jmp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_RUN;
            S_RUN:          if (halt_acc) state_nxt = S_HALT;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic        lbl_we = 1'b0;
    logic [3:0]  lbl_idx = '0;
    logic [15:0] lbl_data = '0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [1:0]  format;
    logic [3:0]  opcode;
    logic [2:0]  reg1_i, reg2_i, reg_o, imm;
    logic        imm_flag;
    logic [15:0] jmp_loc;
    logic        halted, busy;

    instr_fetch_unit #(.PC_W(16), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .lbl_we(lbl_we), .lbl_idx(lbl_idx), .lbl_data(lbl_data),
        .start(start), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .format(format), .opcode(opcode), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .reg_o(reg_o), .imm(imm), .imm_flag(imm_flag), .jmp_loc(jmp_loc),
        .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [34:0] dec;  // {format, opcode, reg1, reg2, rego, imm, imm_flag, jmp}
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    exp_t        mon_e;
    logic [34:0] mon_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [1:0] f, input logic [3:0] op,
                        input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] ro,
                        input logic [2:0] im, input logic imf, input logic [15:0] jmp);
        exp_t e;
        e.pc  = pc;
        e.dec = {f, op, r1, r2, ro, im, imf, jmp};
        sb.push_back(e);
    endtask

    // Monitor: an instruction is consumed when valid and ready meet, except
    // when a redirect discards it (a HALT being accepted is never discarded).
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && (!redirect_valid || opcode == 4'hE)) begin
            mon_got = {format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag, jmp_loc};
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept actual_pc=%h required=none", out_pc);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (out_pc !== mon_e.pc) begin
                    bad++;
                    $display("FAIL accept_pc actual=%h required=%h", out_pc, mon_e.pc);
                end
                total++;
                if (mon_got !== mon_e.dec) begin
                    bad++;
                    $display("FAIL decode_pc%h actual=%h required=%h", mon_e.pc, mon_got, mon_e.dec);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic write_lbl(input logic [3:0] i, input logic [15:0] d);
        lbl_we = 1'b1; lbl_idx = i; lbl_data = d;
        cyc();
        lbl_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [15:0] pc, output logic found);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (out_valid && out_pc == pc) found = 1'b1;
            else cyc();
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_pc_%h actual=timeout required=presented", pc);
        end
    endtask

    task automatic redirect_at(input logic [15:0] pc, input logic [15:0] tgt,
                               input logic chk, input logic [15:0] jmp_req);
        logic found;
        wait_pc(pc, found);
        if (found) begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
            if (chk) check("redirect_jmp_loc", 32'(jmp_loc), 32'(jmp_req));
            cyc();
            redirect_valid = 1'b0;
        end
    endtask

    task automatic wait_halted(input string name);
        for (int i = 0; i < 100 && !halted; i++) cyc();
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // pc0..pc4 holding 30..34 (M format, opcode 3)
    task automatic push_ramp();
        push(16'd0, 2'b10, 4'h3, 3'd0, 3'd1, 3'd4, 3'd0, 1'b0, 16'h100C);
        push(16'd1, 2'b10, 4'h3, 3'd0, 3'd1, 3'd5, 3'd0, 1'b1, 16'h002E);
        push(16'd2, 2'b10, 4'h3, 3'd0, 3'd1, 3'd6, 3'd1, 1'b0, 16'h100E);
        push(16'd3, 2'b10, 4'h3, 3'd0, 3'd1, 3'd7, 3'd1, 1'b1, 16'h100F);
        push(16'd4, 2'b10, 4'h3, 3'd1, 3'd2, 3'd4, 3'd2, 1'b0, 16'h100C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        cyc();
        cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_dec", 32'({format, opcode, reg1_i, reg2_i, reg_o, jmp_loc}), 32'd0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 16; i++) write_lbl(4'(i), 16'h1000 + 16'(i));

        // Basic C/C/X sequence
        write_mem(8'd0, 8'h4A);
        write_mem(8'd1, 8'h45);
        write_mem(8'd2, 8'hE0);
        push(16'd0, 2'b00, 4'h4, 3'd0, 3'd0, 3'd2, 3'd5, 1'b0, 16'h100A);
        push(16'd1, 2'b00, 4'h4, 3'd0, 3'd0, 3'd3, 3'd2, 1'b1, 16'h1005);
        push(16'd2, 2'b11, 4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        out_ready = 1'b1;
        pulse_start();
        check("start_lat_valid0", 32'(out_valid), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        cyc();
        check("start_lat_valid1", 32'(out_valid), 32'd1);
        check("start_lat_pc", 32'(out_pc), 32'd0);
        wait_halted("seq1");

        // Backpressure hold on an I-format instruction
        write_mem(8'd0, 8'h94);
        write_mem(8'd1, 8'h4A);
        push(16'd0, 2'b01, 4'h9, 3'd2, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000);
        push(16'd1, 2'b00, 4'h4, 3'd0, 3'd0, 3'd2, 3'd5, 1'b0, 16'h100A);
        push(16'd2, 2'b11, 4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        out_ready = 1'b0;
        pulse_start();
        wait_pc(16'd0, found);
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_pc", 32'(out_pc), 32'd0);
            check("hold_fmt", 32'(format), 32'd1);
            check("hold_regs", 32'({reg1_i, reg2_i}), 32'({3'd2, 3'd3}));
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("release_pc", 32'(out_pc), 32'd1);
        check("release_valid", 32'(out_valid), 32'd1);
        wait_halted("hold");

        // Redirect through label 13, landing on MVB then HALT
        write_lbl(4'd13, 16'h002E);
        write_mem(8'd0, 8'h30);
        write_mem(8'd1, 8'h31);
        write_mem(8'd2, 8'h32);
        write_mem(8'd3, 8'h33);
        write_mem(8'd4, 8'h34);
        write_mem(8'd5, 8'hB1);
        write_mem(8'h2E, 8'h57);
        write_mem(8'h2F, 8'hE0);
        push_ramp();
        push(16'h002E, 2'b10, 4'h5, 3'd7, 3'd0, 3'd1, 3'd3, 1'b1, 16'h100F);
        push(16'h002F, 2'b11, 4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        pulse_start();
        redirect_at(16'd5, 16'h002E, 1'b1, 16'h002E);
        check("redir_bubble", 32'(out_valid), 32'd0);
        cyc();
        check("redir_next_pc", 32'(out_pc), 32'h2E);
        wait_halted("redir");

        // Out-of-range fetch decodes as HALT; redirect during HALT accept ignored
        push(16'h0100, 2'b11, 4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        pulse_start();
        redirect_at(16'd0, 16'h0100, 1'b0, 16'h0000);
        redirect_at(16'h0100, 16'h0000, 1'b0, 16'h0000);
        wait_halted("oob");

        // Reset mid-stream, ignored writes during RUN, restart from pc 0
        write_mem(8'd6, 8'h94);
        write_mem(8'd7, 8'h45);
        write_mem(8'd8, 8'hE0);
        push_ramp();
        push(16'd5, 2'b10, 4'hB, 3'd0, 3'd1, 3'd5, 3'd0, 1'b1, 16'h002E);
        push(16'd6, 2'b01, 4'h9, 3'd2, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000);
        pulse_start();
        wait_pc(16'd7, found);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pc", 32'(out_pc), 32'd0);
        check("midrst_sb_drained", 32'(sb.size()), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        push_ramp();
        push(16'd5, 2'b10, 4'hB, 3'd0, 3'd1, 3'd5, 3'd0, 1'b1, 16'h002E);
        push(16'd6, 2'b01, 4'h9, 3'd2, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000);
        push(16'd7, 2'b00, 4'h4, 3'd0, 3'd0, 3'd3, 3'd2, 1'b1, 16'h1005);
        push(16'd8, 2'b11, 4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        pulse_start();
        start = 1'b1;
        prog_we = 1'b1; prog_addr = 8'd1; prog_data = 8'hE0;
        lbl_we = 1'b1; lbl_idx = 4'd12; lbl_data = 16'hBEEF;
        cyc();
        start = 1'b0; prog_we = 1'b0; lbl_we = 1'b0;
        wait_halted("restart");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16: program-counter and jump-target width.
REQ-002 SHALL have parameter DEPTH, default 256: program memory entries, power of two, at most 2^PC_W.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH): program-load address width.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high reset
- prog_we  in  1  program memory write strobe
- prog_addr  in  AW  program write address
- prog_data  in  8  instruction byte
- lbl_we  in  1  jump-label write strobe
- lbl_idx  in  4  label index, 16 entries
- lbl_data  in  PC_W  label target
- start  in  1  begin execution at pc 0
- redirect_valid  in  1  taken branch or jump
- redirect_pc  in  PC_W  new fetch address
- out_ready  in  1  consumer accepts the decoded instruction
- out_valid  out  1  decoded instruction present
- out_pc  out  PC_W  pc of the presented instruction
- format  out  2  00 C, 01 I, 10 M, 11 X
- opcode  out  4  instr[7:4]
- reg1_i, reg2_i, reg_o  out  3 each  register indices
- imm  out  3  instr[3:1]
- imm_flag  out  1  instr[0]
- jmp_loc  out  PC_W  label-table target
- halted  out  1  HALT instruction accepted
- busy  out  1  state is RUN

Function
REQ-005 SHALL implement three states, IDLE, RUN and HALT:
- IDLE -> RUN on start.
- HALT -> RUN on start.
- RUN -> HALT when a HALT-opcode (1110) instruction is accepted.
- start while in RUN is ignored.
REQ-006 SHALL ignore program and label writes while in RUN; writes in IDLE or HALT take effect on the next edge.
REQ-007 SHALL leave program memory and label table uninitialised by reset, so that contents survive reset.
REQ-008 SHALL read program memory combinationally from fetch_pc; every decoded output SHALL be registered.
REQ-009 SHALL define "load" in RUN as (!out_valid | out_ready):
- On load, the output register captures the decode of mem[fetch_pc].
- out_pc <= fetch_pc.
- out_valid <= 1.
- fetch_pc <= fetch_pc + 1, wrapping modulo 2^PC_W.
REQ-010 SHALL hold every output stable while out_valid & !out_ready.
REQ-011 SHALL, when start is accepted, set fetch_pc = 0 with out_valid = 0; out_valid SHALL rise on the following cycle, giving a 2-cycle latency from start to the first out_valid.
REQ-012 SHALL, on redirect_valid in RUN, take redirect ahead of load:
- Set out_valid <= 0 and fetch_pc <= redirect_pc.
- The next cycle performs a load from redirect_pc.
- The instruction presented during the redirect cycle is discarded, even if out_ready = 1.
REQ-013 SHALL decode a fetch_pc at or above DEPTH as instruction 8'hE0 (HALT).
REQ-014 SHALL map format by opcode:
- C: 0010, 0100.
- I: 1001, 1101.
- X: 1110.
- M: all other opcodes.
REQ-015 SHALL set register outputs by format:
- C: reg_o = instr[0] ? 3'b011 : 3'b010.
- I: reg1_i = instr[3:1]; reg2_i = reg1_i + 1 (3-bit wrap); reg_o = reg1_i.
- M with opcode 0101: reg1_i = {1, instr[1:0]}; reg_o = {0, instr[3:2]}.
- Other M: reg1_i = {0, instr[3:2]}; reg2_i = reg1_i + 1; reg_o = {1, instr[1:0]}.
- Any unassigned register field = 0.
REQ-016 SHALL set jmp_loc by format:
- C: jmp_loc = label[instr[3:0]].
- M: jmp_loc = label[{2'b11, instr[1:0]}].
- I and X: jmp_loc = 0.
REQ-017 SHALL, on acceptance of a HALT instruction (out_valid & out_ready with opcode 1110):
- Enter HALT.
- Set out_valid <= 0 and halted <= 1.
- Suppress any further load.
REQ-018 SHALL ignore redirect_valid outside RUN; a redirect in the same cycle as HALT acceptance SHALL also be ignored.
REQ-019 SHALL clear halted when start is accepted.

Reset
REQ-020 SHALL, while reset is high, force state = IDLE, fetch_pc = 0, out_valid = 0, halted = 0 and busy = 0, and set all decoded outputs and out_pc to 0.
REQ-021 SHALL abandon any in-flight instruction on reset asserted mid-RUN; the next start re-fetches from pc 0 with unchanged memory.

Verification
REQ-022 Bench SHALL load mem[0..2] = 4A, 45, E0 and pulse start -> exact sequence:
- pc0: C, reg_o = 2.
- pc1: C, reg_o = 3.
- pc2: X.
- Then halted = 1, out_valid = 0.
REQ-023 Bench SHALL present mem[0] = 94 with out_ready low for 3 cycles -> outputs hold pc0, I, reg1_i = 2, reg2_i = 3; after release, pc1 appears on the next cycle.
REQ-024 Bench SHALL set label[13] = 0x002E, load B1 at pc5, and assert redirect to 0x2E while pc5 is presented -> jmp_loc = 0x2E; next out_pc = 0x2E; pc5 never accepted.
REQ-025 Bench SHALL load 57 (MVB) -> reg1_i = 7, reg_o = 1, reg2_i = 0.
REQ-026 Bench SHALL redirect to DEPTH (256) -> decoded X at out_pc = 0x100; acceptance sets halted.
REQ-027 Bench SHALL assert reset mid-stream at pc 7, then attempt prog_we during RUN, then restart -> execution restarts at pc 0, memory unchanged, the RUN write has no effect.
